// File: rtl/mul_pipe_tracker.sv
// Pipelined M-extension multiplier with in-flight rd tracking.
// Exposes per-stage valid/rd and a RAW/WAW stall request for ID.
module mul_pipe_tracker #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       use_i,
    input  logic [1:0]                 mult_type_i,
    input  logic [XLEN-1:0]            a_i,
    input  logic [XLEN-1:0]            b_i,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    input  logic                       flush_i,
    input  logic                       rs1_re_id_i,
    input  logic [ADDR_W-1:0]          rs1_addr_id_i,
    input  logic                       rs2_re_id_i,
    input  logic [ADDR_W-1:0]          rs2_addr_id_i,
    input  logic                       rd_we_id_i,
    input  logic [ADDR_W-1:0]          rd_addr_id_i,
    output logic [STAGES-1:0]          valid_o,
    output logic [STAGES*ADDR_W-1:0]   rd_addrs_o,
    output logic                       done_o,
    output logic [ADDR_W-1:0]          rd_addr_o,
    output logic [XLEN-1:0]            rd_data_o,
    output logic                       busy_o,
    output logic                       stall_req_o
);

    logic [STAGES-1:0]        valid_q, valid_d;
    logic [STAGES*ADDR_W-1:0] rd_q, rd_d;
    logic [STAGES*XLEN-1:0]   data_q, data_d;

    logic                     issue;
    logic                     a_sgn, b_sgn;
    logic [2*XLEN-1:0]        a_w, b_w, prod;
    logic [XLEN-1:0]          res;

    assign issue = use_i & ~flush_i;

    // Operand extension: the low 2*XLEN product bits are exact for
    // every signedness mix, so a plain 2*XLEN multiply is sufficient.
    always_comb begin
        a_sgn = (mult_type_i != 2'b11);
        b_sgn = ~mult_type_i[1];
        a_w   = {{XLEN{a_sgn & a_i[XLEN-1]}}, a_i};
        b_w   = {{XLEN{b_sgn & b_i[XLEN-1]}}, b_i};
        prod  = a_w * b_w;
        res   = (mult_type_i == 2'b00) ? prod[XLEN-1:0]
                                       : prod[2*XLEN-1:XLEN];
    end

    // Shift every stage forward; bubbles carry zero addr/data.
    always_comb begin
        valid_d = '0;
        rd_d    = '0;
        data_d  = '0;
        valid_d[0] = issue;
        rd_d[0 +: ADDR_W] = issue ? rd_addr_i : '0;
        data_d[0 +: XLEN] = issue ? res : '0;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            rd_d[i*ADDR_W +: ADDR_W] = rd_q[(i-1)*ADDR_W +: ADDR_W];
            data_d[i*XLEN +: XLEN] = data_q[(i-1)*XLEN +: XLEN];
        end
    end

    // Pipeline registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // Hazard check against every in-flight rd, completing stage included.
    always_comb begin
        logic [ADDR_W-1:0] r;
        stall_req_o = 1'b0;
        r = '0;
        for (int i = 0; i < STAGES; i++) begin
            r = rd_q[i*ADDR_W +: ADDR_W];
            if (valid_q[i] && (r != '0)) begin
                if ((rs1_re_id_i && (rs1_addr_id_i == r)) ||
                    (rs2_re_id_i && (rs2_addr_id_i == r)) ||
                    (rd_we_id_i  && (rd_addr_id_i  == r)))
                    stall_req_o = 1'b1;
            end
        end
    end

    assign valid_o    = valid_q;
    assign rd_addrs_o = rd_q;
    assign done_o     = valid_q[STAGES-1];
    assign rd_addr_o  = rd_q[(STAGES-1)*ADDR_W +: ADDR_W];
    assign rd_data_o  = data_q[(STAGES-1)*XLEN +: XLEN];
    assign busy_o     = |valid_q;

endmodule

// File: tb/tb_mul_pipe_tracker.sv
// Bench for mul_pipe_tracker: STAGES=1/3/5 against an issue-history model.
// Directed known answers plus randomized traffic.
module tb_mul_pipe_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        use_i = 1'b0;
    logic [1:0]  mt = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        r1e = 1'b0, r2e = 1'b0, we = 1'b0;
    logic [4:0]  r1 = '0, r2 = '0, rw = '0;

    logic [0:0]  v1;
    logic [4:0]  ra1;
    logic [2:0]  v3;
    logic [14:0] ra3;
    logic [4:0]  v5;
    logic [24:0] ra5;
    logic        dn1, dn3, dn5, bz1, bz3, bz5, st1, st3, st5;
    logic [4:0]  ro1, ro3, ro5;
    logic [31:0] d1, d3, d5;

    int errors = 0;
    int checks = 0;

    bit          hv[0:4095];
    logic [4:0]  hrd[0:4095];
    logic [31:0] hdat[0:4095];
    int          nedge = 0;
    int          last_rst = 0;

    always #5 clk = ~clk;

    mul_pipe_tracker #(.XLEN(32), .STAGES(1), .ADDR_W(5)) u1 (
        .clk(clk), .rst(rst), .use_i(use_i), .mult_type_i(mt),
        .a_i(a), .b_i(b), .rd_addr_i(rd), .flush_i(flush),
        .rs1_re_id_i(r1e), .rs1_addr_id_i(r1),
        .rs2_re_id_i(r2e), .rs2_addr_id_i(r2),
        .rd_we_id_i(we), .rd_addr_id_i(rw),
        .valid_o(v1), .rd_addrs_o(ra1), .done_o(dn1),
        .rd_addr_o(ro1), .rd_data_o(d1), .busy_o(bz1),
        .stall_req_o(st1));

    mul_pipe_tracker #(.XLEN(32), .STAGES(3), .ADDR_W(5)) u3 (
        .clk(clk), .rst(rst), .use_i(use_i), .mult_type_i(mt),
        .a_i(a), .b_i(b), .rd_addr_i(rd), .flush_i(flush),
        .rs1_re_id_i(r1e), .rs1_addr_id_i(r1),
        .rs2_re_id_i(r2e), .rs2_addr_id_i(r2),
        .rd_we_id_i(we), .rd_addr_id_i(rw),
        .valid_o(v3), .rd_addrs_o(ra3), .done_o(dn3),
        .rd_addr_o(ro3), .rd_data_o(d3), .busy_o(bz3),
        .stall_req_o(st3));

    mul_pipe_tracker #(.XLEN(32), .STAGES(5), .ADDR_W(5)) u5 (
        .clk(clk), .rst(rst), .use_i(use_i), .mult_type_i(mt),
        .a_i(a), .b_i(b), .rd_addr_i(rd), .flush_i(flush),
        .rs1_re_id_i(r1e), .rs1_addr_id_i(r1),
        .rs2_re_id_i(r2e), .rs2_addr_id_i(r2),
        .rd_we_id_i(we), .rd_addr_id_i(rw),
        .valid_o(v5), .rd_addrs_o(ra5), .done_o(dn5),
        .rd_addr_o(ro5), .rd_data_o(d5), .busy_o(bz5),
        .stall_req_o(st5));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference arithmetic via 64-bit integer math.
    function automatic logic [31:0] ref_mul(input logic [1:0] t,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (t)
            2'b00: p = sx * sy;
            2'b01: p = sx * sy;
            2'b10: p = sx * uy;
            default: p = ux * uy;
        endcase
        return (t == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // After nedge edges, stage i of a depth-s pipe holds edge nedge-i.
    task automatic check_dut(input int s, input logic [4:0] v,
                             input logic [24:0] ra, input logic dn,
                             input logic [4:0] ro, input logic [31:0] dat,
                             input logic bz, input logic st);
        logic [4:0]  ev;
        logic [24:0] era;
        logic [31:0] edat;
        logic        est;
        logic [4:0]  r;
        int          e;
        ev = '0; era = '0; edat = '0; est = 1'b0;
        for (int i = 0; i < s; i++) begin
            e = nedge - i;
            if (e >= 1 && e > last_rst && hv[e]) begin
                r = hrd[e];
                ev[i] = 1'b1;
                era[i*5 +: 5] = r;
                if (i == s - 1) edat = hdat[e];
                if (r != 0 && ((r1e && r1 == r) || (r2e && r2 == r) ||
                               (we && rw == r)))
                    est = 1'b1;
            end
        end
        chk($sformatf("S%0d.valid", s), 64'(v), 64'(ev));
        chk($sformatf("S%0d.rd_addrs", s), 64'(ra), 64'(era));
        chk($sformatf("S%0d.done", s), 64'(dn), 64'(ev[s-1]));
        chk($sformatf("S%0d.rd_addr", s), 64'(ro), 64'(era[(s-1)*5 +: 5]));
        chk($sformatf("S%0d.rd_data", s), 64'(dat), 64'(edat));
        chk($sformatf("S%0d.busy", s), 64'(bz), 64'(|ev));
        chk($sformatf("S%0d.stall", s), 64'(st), 64'(est));
    endtask

    // One cycle: drive at negedge, check, record the edge; returns #1 after it.
    task automatic drive(input bit u = 0, input logic [1:0] t = 0,
                         input logic [31:0] x = 0, input logic [31:0] y = 0,
                         input logic [4:0] d = 0, input bit fl = 0,
                         input bit rs = 1, input bit e1 = 0,
                         input logic [4:0] a1 = 0, input bit e2 = 0,
                         input logic [4:0] a2 = 0, input bit ew = 0,
                         input logic [4:0] aw = 0);
        @(negedge clk);
        use_i = u; mt = t; a = x; b = y; rd = d; flush = fl; rst = rs;
        r1e = e1; r1 = a1; r2e = e2; r2 = a2; we = ew; rw = aw;
        #1;
        if (nedge > 0) begin
            check_dut(1, 5'(v1), 25'(ra1), dn1, ro1, d1, bz1, st1);
            check_dut(3, 5'(v3), 25'(ra3), dn3, ro3, d3, bz3, st3);
            check_dut(5, v5, ra5, dn5, ro5, d5, bz5, st5);
        end
        @(posedge clk);
        nedge++;
        hv[nedge] = u && !fl && rs;
        hrd[nedge] = d;
        hdat[nedge] = ref_mul(t, x, y);
        if (!rs) last_rst = nedge;
        #1;
    endtask

    task automatic kat(input logic [1:0] t, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] d,
                       input logic [31:0] exp, input string tag);
        drive(1, t, x, y, d);
        drive();
        chk({tag, ".pre_done"}, 64'(dn3), 64'd0);
        drive();
        chk({tag, ".done"}, 64'(dn3), 64'd1);
        chk({tag, ".data"}, 64'(d3), 64'(exp));
        chk({tag, ".rd"}, 64'(ro3), 64'(d));
    endtask

    initial begin
        drive(1, 0, 32'd3, 32'd3, 5'd9, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive();
        drive();
        chk("idle.data", 64'(d3), 64'd0);

        kat(2'b00, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, "mul");
        kat(2'b01, 32'h80000000, 32'h80000000, 5'd7, 32'h40000000, "mulh");
        kat(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, "mulhu");
        kat(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 32'hFFFFFFFF, "mulhsu");
        repeat (3) drive();

        for (int i = 1; i <= 4; i++)
            drive(1, 0, 32'd2, 32'(i), 5'(i));
        repeat (6) drive();

        drive(1, 0, 32'd5, 32'd5, 5'd6);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd6);
        drive(1, 0, 32'd5, 32'd5, 5'd0);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0);
        drive(1, 0, 32'd5, 32'd5, 5'd6);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5'd6);

        drive(1, 0, 32'd4, 32'd4, 5'd3, 1);
        repeat (5) drive();

        drive(1, 1, 32'd11, 32'd13, 5'd4);
        drive();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst.busy", 64'(bz3), 64'd0);
        repeat (6) drive();

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom),
                  $urandom, $urandom, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 40) != 0,
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)));
        end
        repeat (6) drive();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_pipe_tracker.md
Name: mul_pipe_tracker

Overview:
Parametrised pipelined multiplier with in-flight destination tracking for the 5-stage RV32 core. It accepts one M-extension multiply per cycle from EX and returns the result a fixed STAGES cycles later. It exposes every in-flight rd address and valid bit. It also raises a combinational stall request for RAW/WAW hazards against the instruction in ID.

Parameters:
XLEN, 32, operand/result width
STAGES, 3, pipeline depth = issue-to-done latency in cycles (>=1)
ADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
use_i  in  1  issue a multiply this cycle
mult_type_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
a_i  in  XLEN  rs1 operand
b_i  in  XLEN  rs2 operand
rd_addr_i  in  ADDR_W  destination of issued op
flush_i  in  1  kill the op issued this cycle
rs1_re_id_i  in  1  ID reads rs1
rs1_addr_id_i  in  ADDR_W  ID rs1 address
rs2_re_id_i  in  1  ID reads rs2
rs2_addr_id_i  in  ADDR_W  ID rs2 address
rd_we_id_i  in  1  ID writes rd
rd_addr_id_i  in  ADDR_W  ID rd address
valid_o  out  STAGES  per-stage valid, bit 0 = youngest
rd_addrs_o  out  STAGES*ADDR_W  per-stage rd, stage i at bits [i*ADDR_W +: ADDR_W]
done_o  out  1  result valid this cycle (= valid_o[STAGES-1])
rd_addr_o  out  ADDR_W  destination of completing op
rd_data_o  out  XLEN  result of completing op
busy_o  out  1  OR of valid_o
stall_req_o  out  1  hazard stall request to stall control

Behaviour:
- Reset: rst low at a rising edge clears all stage valids, rd addresses and data regs. All outputs read 0 the following cycle. Reset mid-operation discards every in-flight op; no done_o is produced for them.
- Issue: use_i=1 and flush_i=0, sampled at edge k, loads stage 0. valid_o[0]=1 in cycle k+1.
- Advance: each edge, stage i moves to i+1 unconditionally. There is no backpressure and no freeze on core stalls. One issue per cycle gives full throughput.
- Latency: done_o=1 exactly in cycle k+STAGES, with rd_addr_o and rd_data_o for that op. With STAGES=1, done_o comes the cycle after issue.
- flush_i=1 suppresses only the same-cycle issue. Older in-flight ops are unaffected.
- use_i=0 inserts a bubble: valid=0, and addr/data are don't-care but held at 0.
- Arithmetic: form a 2*XLEN product from operands extended per type.
  - MUL: both operands signed; result = low XLEN.
  - MULH: both signed; result = high XLEN.
  - MULHSU: a signed, b unsigned; result = high XLEN.
  - MULHU: both unsigned; result = high XLEN.
- Arithmetic may be split across stages freely, but latency and results are exact.
- stall_req_o (combinational) = 1 if any stage i has valid_o[i]=1 and rd_addrs[i]!=0 and at least one of these holds:
  - rs1_re_id_i=1 and rs1_addr_id_i==rd_addrs[i]
  - rs2_re_id_i=1 and rs2_addr_id_i==rd_addrs[i]
  - rd_we_id_i=1 and rd_addr_id_i==rd_addrs[i] (WAW)
- The completing stage is included in the hazard check (conservative).
- x0 rule: rd=0 never causes a stall. An op with rd=0 still flows and asserts done_o.
- The stall request does not block issue. Stall control holds ID; this block keeps draining.
- Outputs valid_o, rd_addrs_o, done_o, rd_addr_o and rd_data_o are registered. busy_o and stall_req_o are combinational.

Test Plan:
- Reset then idle: rst=0 two cycles, release -> valid_o=0, done_o=0, rd_data_o=0, stall_req_o=0.
- Types (STAGES=3): check each op, with done_o exactly 3 cycles after issue.
  - MUL 7 x 0xFFFFFFFD, rd=5 -> rd_data_o=0xFFFFFFEB, rd_addr_o=5.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Back-to-back: issue 4 MULs on consecutive cycles (rd=1..4, 2x1, 2x2, 2x3, 2x4) -> done_o high 4 consecutive cycles with 2, 4, 6, 8 in order; valid_o sequence 001, 011, 111, 111, 110, 100.
- Hazard: issue MUL rd=6, then ID rs2_re=1 rs2_addr=6 -> stall_req_o=1 for 3 cycles, 0 after done. Same test with rd=0 -> stall_req_o stays 0. ID rd_we=1 rd_addr=6 -> stall_req_o=1 (WAW).
- Flush/reset: use_i=1 with flush_i=1 -> no valid, no done. Issue then rst=0 at cycle 2 -> done_o never asserts; busy_o=0 after reset.
- Parameter sweep STAGES=1 and STAGES=5 -> latency 1 and 5; rd_addrs_o packing checked per stage.
